// File: rtl/store_merge_if.sv
// Store request and data-RAM port bundle for store_merge_unit.
// master = requester/RAM side, slave = the merge unit.
interface store_merge_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_op;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;

    modport master (
        output req_valid, req_addr, req_data, req_op, mem_rdata,
        input  req_ready, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_op, mem_rdata,
        output req_ready, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/store_merge_unit.sv
// SB/SH/SW executor for a word-wide RAM without byte strobes: read the old word,
// merge the store lanes, write the word back. Misaligned or reserved ops end in err.
module store_merge_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input logic          clk,
    input logic          rst_n,
    store_merge_if.slave bus_io
);
    localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(RD_LAT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StErr} state_e;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        op_q, op_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       old_q, old_d;
    logic [31:0]       merged;
    logic [1:0]        off;
    logic [1:0]        req_off;
    logic              accept;

    assign off     = addr_q[1:0];
    assign req_off = bus_io.req_addr[1:0];
    assign accept  = bus_io.req_valid && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            old_q   <= old_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        old_d   = old_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = bus_io.req_addr;
                    data_d = bus_io.req_data;
                    op_d   = bus_io.req_op;
                    case (bus_io.req_op)
                        2'b00:   state_d = StRead;
                        2'b01:   state_d = (req_off == 2'd3) ? StErr : StRead;
                        2'b10:   state_d = (req_off != 2'd0) ? StErr : StWrite;
                        default: state_d = StErr;
                    endcase
                end
            end
            StRead: begin
                cnt_d   = CntInit;
                state_d = StWait;
            end
            StWait: begin
                // Last wait cycle is exactly RD_LAT cycles after the read strobe.
                if (cnt_q == '0) begin
                    old_d   = bus_io.mem_rdata;
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StWrite: state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
    end

    always_comb begin
        merged = old_q;
        case (op_q)
            2'b00: begin
                case (off)
                    2'd0: merged[7:0]   = data_q[7:0];
                    2'd1: merged[15:8]  = data_q[7:0];
                    2'd2: merged[23:16] = data_q[7:0];
                    2'd3: merged[31:24] = data_q[7:0];
                    default: ;
                endcase
            end
            2'b01: begin
                case (off)
                    2'd0: merged[15:0]  = data_q[15:0];
                    2'd1: merged[23:8]  = data_q[15:0];
                    2'd2: merged[31:16] = data_q[15:0];
                    default: ;
                endcase
            end
            2'b10:   merged = data_q;
            default: ;
        endcase
    end

    always_comb begin
        bus_io.req_ready = ready_q;
        bus_io.mem_rd_en = (state_q == StRead);
        bus_io.mem_wr_en = (state_q == StWrite);
        bus_io.done      = (state_q == StWrite) || (state_q == StErr);
        bus_io.err       = (state_q == StErr);
        bus_io.mem_addr  = (state_q == StIdle) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
        bus_io.mem_wdata = (state_q == StWrite) ? merged : 32'h0;
    end
endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: vector table on an RD_LAT=1 instance,
// plus reset-abort and back-to-back sequences (the latter on an RD_LAT=3 instance).
module tb_store_merge_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_merge_if #(.ADDR_W(32)) bus_a ();
    store_merge_if #(.ADDR_W(32)) bus_b ();

    store_merge_unit #(.ADDR_W(32), .RD_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus_io(bus_a));
    store_merge_unit #(.ADDR_W(32), .RD_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus_io(bus_b));

    // RAM model: reads only; rdata carries a marker when no read is returning.
    logic [31:0] ram [256];
    logic [31:0] pipe_a = 32'hDEAD_0000;
    logic [31:0] pipe_b0 = 32'hDEAD_0000, pipe_b1 = 32'hDEAD_0000, pipe_b2 = 32'hDEAD_0000;
    int unsigned wr_cnt_a = 0;

    always @(posedge clk) begin
        pipe_a  <= bus_a.mem_rd_en ? ram[bus_a.mem_addr[9:2]] : 32'hDEAD_0000;
        pipe_b0 <= bus_b.mem_rd_en ? ram[bus_b.mem_addr[9:2]] : 32'hDEAD_0000;
        pipe_b1 <= pipe_b0;
        pipe_b2 <= pipe_b1;
        if (bus_a.mem_wr_en) wr_cnt_a <= wr_cnt_a + 1;
    end
    assign bus_a.mem_rdata = pipe_a;
    assign bus_b.mem_rdata = pipe_b2;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] old;
        logic        exp_err;
        logic        exp_rd;
        logic [31:0] exp_wdata;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] old,
                                input logic e, input logic rd, input logic [31:0] wd,
                                input int lat);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.old = old;
        v.exp_err = e; v.exp_rd = rd; v.exp_wdata = wd; v.exp_lat = lat;
        return v;
    endfunction

    vec_t vecs [12];

    task automatic wait_ready_a(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            if (bus_a.req_ready) break;
            @(negedge clk);
        end
        check(name, {31'd0, bus_a.req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int rd_cyc = 0, wr_cyc = 0, done_cyc = 0;
        logic err_v = 1'b0, both = 1'b0;
        logic [31:0] wdata = 0, waddr = 0, raddr = 0;
        logic [31:0] word;
        word = {v.addr[31:2], 2'b00};
        ram[v.addr[9:2]] = v.old;
        wait_ready_a($sformatf("v%0d_ready", idx));
        bus_a.req_valid = 1'b1;
        bus_a.req_addr  = v.addr;
        bus_a.req_data  = v.data;
        bus_a.req_op    = v.op;
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus_a.mem_rd_en && rd_cyc == 0) begin rd_cyc = c; raddr = bus_a.mem_addr; end
            if (bus_a.mem_wr_en && wr_cyc == 0) begin
                wr_cyc = c; wdata = bus_a.mem_wdata; waddr = bus_a.mem_addr;
            end
            if (bus_a.mem_rd_en && bus_a.mem_wr_en) both = 1'b1;
            if (bus_a.done) begin done_cyc = c; err_v = bus_a.err; break; end
            @(posedge clk);
            #1;
        end
        check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_lat);
        check($sformatf("v%0d_err", idx), {31'd0, err_v}, {31'd0, v.exp_err});
        check($sformatf("v%0d_rd_cycle", idx), rd_cyc, v.exp_rd ? 1 : 0);
        check($sformatf("v%0d_wr_cycle", idx), wr_cyc, v.exp_err ? 0 : v.exp_lat);
        check($sformatf("v%0d_rd_wr_overlap", idx), {31'd0, both}, 32'd0);
        if (!v.exp_err) begin
            check($sformatf("v%0d_wdata", idx), wdata, v.exp_wdata);
            check($sformatf("v%0d_waddr", idx), waddr, word);
        end
        if (v.exp_rd) check($sformatf("v%0d_raddr", idx), raddr, word);
        @(negedge clk);
    endtask

    initial begin
        bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.req_data = '0; bus_a.req_op = '0;
        bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_data = '0; bus_b.req_op = '0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;

        vecs[0]  = mk(2'b00, 32'h102, 32'h0000_00AB, 32'h1122_3344, 0, 1, 32'h11AB_3344, 3);
        vecs[1]  = mk(2'b00, 32'h104, 32'hFFFF_FF55, 32'hAABB_CCDD, 0, 1, 32'hAABB_CC55, 3);
        vecs[2]  = mk(2'b00, 32'h107, 32'h0000_0077, 32'h0000_0000, 0, 1, 32'h7700_0000, 3);
        vecs[3]  = mk(2'b00, 32'h109, 32'h0000_00C3, 32'h0123_4567, 0, 1, 32'h0123_C367, 3);
        vecs[4]  = mk(2'b01, 32'h101, 32'h0000_BEEF, 32'hAABB_CCDD, 0, 1, 32'hAABE_EFDD, 3);
        vecs[5]  = mk(2'b01, 32'h102, 32'h0000_1234, 32'hAABB_CCDD, 0, 1, 32'h1234_CCDD, 3);
        vecs[6]  = mk(2'b01, 32'h100, 32'hFFFF_5678, 32'h1122_3344, 0, 1, 32'h1122_5678, 3);
        vecs[7]  = mk(2'b10, 32'h200, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0, 32'hDEAD_BEEF, 1);
        vecs[8]  = mk(2'b01, 32'h103, 32'h0000_1111, 32'h9999_9999, 1, 0, 32'h0, 1);
        vecs[9]  = mk(2'b10, 32'h202, 32'h2222_2222, 32'h9999_9999, 1, 0, 32'h0, 1);
        vecs[10] = mk(2'b11, 32'h100, 32'h3333_3333, 32'h9999_9999, 1, 0, 32'h0, 1);
        vecs[11] = mk(2'b10, 32'h201, 32'h4444_4444, 32'h9999_9999, 1, 0, 32'h0, 1);

        // Power-on reset: all outputs low, ready one cycle after release.
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {27'd0, bus_a.req_ready, bus_a.done, bus_a.err,
              bus_a.mem_rd_en, bus_a.mem_wr_en}, 32'd0);
        check("rst_mem_addr", bus_a.mem_addr, 32'd0);
        check("rst_mem_wdata", bus_a.mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready_at_release", {31'd0, bus_a.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_ready_after_release", {31'd0, bus_a.req_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset dropped while waiting for read data aborts without a write.
        begin
            int unsigned wcnt0;
            ram[32'h110 >> 2] = 32'h5555_5555;
            wait_ready_a("abort_ready");
            bus_a.req_valid = 1'b1; bus_a.req_addr = 32'h110;
            bus_a.req_data = 32'h99; bus_a.req_op = 2'b00;
            @(posedge clk);
            #1;
            bus_a.req_valid = 1'b0;
            check("abort_read_strobe", {31'd0, bus_a.mem_rd_en}, 32'd1);
            @(posedge clk);
            #2;
            wcnt0 = wr_cnt_a;
            rst_n = 1'b0;
            #1;
            check("abort_outputs", {27'd0, bus_a.req_ready, bus_a.done, bus_a.err,
                  bus_a.mem_rd_en, bus_a.mem_wr_en}, 32'd0);
            check("abort_mem_addr", bus_a.mem_addr, 32'd0);
            check("abort_mem_wdata", bus_a.mem_wdata, 32'd0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("abort_ready_at_release", {31'd0, bus_a.req_ready}, 32'd0);
            @(posedge clk);
            #1;
            check("abort_ready_after_release", {31'd0, bus_a.req_ready}, 32'd1);
            repeat (5) @(posedge clk);
            #1;
            check("abort_no_write", wr_cnt_a, wcnt0);
            @(negedge clk);
        end

        // RD_LAT=3, valid held high across two SB requests.
        begin
            int rd_c[$], wr_c[$], done_c[$];
            logic [31:0] wd[$];
            logic rdy5 = 1'b0, rdy6 = 1'b0, both = 1'b0;
            int k;
            ram[32'h300 >> 2] = 32'hAAAA_AAAA;
            ram[32'h304 >> 2] = 32'hBBBB_BBBB;
            for (k = 0; k < 20; k++) begin
                if (bus_b.req_ready) break;
                @(negedge clk);
            end
            check("b2b_ready", {31'd0, bus_b.req_ready}, 32'd1);
            bus_b.req_valid = 1'b1; bus_b.req_addr = 32'h300;
            bus_b.req_data = 32'h11; bus_b.req_op = 2'b00;
            @(posedge clk);
            #1;
            bus_b.req_addr = 32'h305;
            bus_b.req_data = 32'h22;
            for (int c = 1; c <= 14; c++) begin
                if (bus_b.mem_rd_en) rd_c.push_back(c);
                if (bus_b.mem_wr_en) begin wr_c.push_back(c); wd.push_back(bus_b.mem_wdata); end
                if (bus_b.done) done_c.push_back(c);
                if (bus_b.mem_rd_en && bus_b.mem_wr_en) both = 1'b1;
                if (c == 5) rdy5 = bus_b.req_ready;
                if (c == 6) rdy6 = bus_b.req_ready;
                if (c == 7) bus_b.req_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            check("b2b_rd_count", rd_c.size(), 2);
            check("b2b_wr_count", wr_c.size(), 2);
            check("b2b_rd1", rd_c.size() > 0 ? rd_c[0] : -1, 1);
            check("b2b_wr1", wr_c.size() > 0 ? wr_c[0] : -1, 5);
            check("b2b_done1", done_c.size() > 0 ? done_c[0] : -1, 5);
            check("b2b_rd2", rd_c.size() > 1 ? rd_c[1] : -1, 7);
            check("b2b_wr2", wr_c.size() > 1 ? wr_c[1] : -1, 11);
            check("b2b_wdata1", wd.size() > 0 ? wd[0] : 32'hFFFF_FFFF, 32'hAAAA_AA11);
            check("b2b_wdata2", wd.size() > 1 ? wd[1] : 32'hFFFF_FFFF, 32'hBBBB_22BB);
            check("b2b_ready_in_write", {31'd0, rdy5}, 32'd0);
            check("b2b_ready_idle_after_done", {31'd0, rdy6}, 32'd1);
            check("b2b_rd_wr_overlap", {31'd0, both}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
